// File: rtl/lparray_output_aligner_if.sv
// -----------------------------------------------------------------------------
// lparray_output_aligner_if
//
// Purpose : AXI-Stream bundle used on both sides of the systolic-array output
//           aligner. The same interface carries either a group of narrow lanes
//           (LANES > 1, per-lane handshakes, sideband fields concatenated lane
//           by lane, lane 0 at the LSBs) or one wide stream (LANES = 1).
//
// Signals : tdata  [DATA_W]  payload (all lanes concatenated)
//           tvalid [LANES]   per-lane valid
//           tready [LANES]   per-lane ready (driven by the slave)
//           tlast  [LANES]   per-lane end-of-packet
//           tid    [ID_W]    stream id   (all lanes concatenated)
//           tdest  [DEST_W]  destination (all lanes concatenated)
//           tuser  [USER_W]  user field  (all lanes concatenated)
//
// Modports: master drives payload/valid and samples ready,
//           slave samples payload/valid and drives ready.
// -----------------------------------------------------------------------------
interface lparray_output_aligner_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 16,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [LANES-1:0]  tvalid;
    logic [LANES-1:0]  tready;
    logic [LANES-1:0]  tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport master (
        output tdata, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/lparray_output_aligner.sv
// -----------------------------------------------------------------------------
// lparray_output_aligner
//
// Purpose : Re-aligns the skewed down-lane outputs of a systolic array. Each
//           column lane feeds its own small skew FIFO; once every lane holds at
//           least one beat, the lane heads are presented together as a single
//           wide AXI-Stream beat and popped together. Sideband (tlast/tid/
//           tdest/tuser) is taken from lane 0; disagreement between lanes on
//           tlast or tdest is flagged with a one-cycle error pulse.
//
// Ports   : clk                 clock, rising edge
//           rst                 synchronous reset, active low
//           s_axis  (slave)     PE_NUMBER_I narrow lanes, per-lane handshake
//           m_axis  (master)    one wide aligned stream (LANES = 1)
//           err_tlast_mismatch  pulse: popped heads disagreed on tlast
//           err_dest_mismatch   pulse: popped heads disagreed on tdest
//           err_sticky          any error pulse since reset
// -----------------------------------------------------------------------------
module lparray_output_aligner #(
    parameter int PE_NUMBER_I = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 1,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    lparray_output_aligner_if.slave    s_axis,
    lparray_output_aligner_if.master   m_axis,
    output logic                       err_tlast_mismatch,
    output logic                       err_dest_mismatch,
    output logic                       err_sticky
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Control FSM encoding. The state only tracks occupancy; no output
    // depends on it.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_ALIGNED = 2'd2;
    localparam logic [1:0] ST_STALLED = 2'd3;

    logic                             ready_en_reg;
    logic [PE_NUMBER_I-1:0]           lane_ready;
    logic [PE_NUMBER_I-1:0]           push;
    logic [PE_NUMBER_I-1:0]           not_empty;
    logic [PE_NUMBER_I-1:0]           not_empty_next;
    logic [PE_NUMBER_I-1:0]           head_last;
    logic [PE_NUMBER_I*DATA_WIDTH-1:0] head_data_flat;
    logic [PE_NUMBER_I*ID_WIDTH-1:0]   head_id_flat;
    logic [PE_NUMBER_I*DEST_WIDTH-1:0] head_dest_flat;
    logic [PE_NUMBER_I*USER_WIDTH-1:0] head_user_flat;
    logic                             aligned;
    logic                             pop;
    logic                             tlast_mismatch;
    logic                             dest_mismatch;
    logic                             err_tlast_reg;
    logic                             err_dest_reg;
    logic                             err_sticky_reg;
    logic [1:0]                       state_reg;
    logic [1:0]                       state_next;

    assign aligned = &not_empty;
    assign pop     = aligned & m_axis.tready;

    // Ready is held low through reset and for the reset cycle itself; it comes
    // purely from registers so no input-to-ready combinational path exists.
    assign s_axis.tready = lane_ready;

    // ------------------------------------------------------------------
    // Per-lane skew FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PE_NUMBER_I; gi++) begin : g_lane
            logic [PTR_W-1:0]      wr_ptr_reg;
            logic [PTR_W-1:0]      rd_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            logic [CNT_W-1:0]      count_next;
            logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
            logic                  last_mem [FIFO_DEPTH];

            // A full lane refuses a push even if the same cycle pops it.
            assign lane_ready[gi] = ready_en_reg & (count_reg != FULL_COUNT);
            assign push[gi]       = s_axis.tvalid[gi] & lane_ready[gi];
            assign not_empty[gi]  = (count_reg != '0);

            always_comb begin
                count_next = count_reg + CNT_W'(push[gi]) - CNT_W'(pop);
            end

            assign not_empty_next[gi] = (count_next != '0);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_next;
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    data_mem[wr_ptr_reg] <= s_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH];
                    last_mem[wr_ptr_reg] <= s_axis.tlast[gi];
                end
            end

            assign head_data_flat[gi*DATA_WIDTH +: DATA_WIDTH] = data_mem[rd_ptr_reg];
            assign head_last[gi] = last_mem[rd_ptr_reg];

            // Sideband storage exists only for enabled fields.
            if (ID_ENABLE != 0) begin : g_id
                logic [ID_WIDTH-1:0] id_mem [FIFO_DEPTH];
                always_ff @(posedge clk) begin
                    if (push[gi]) begin
                        id_mem[wr_ptr_reg] <= s_axis.tid[gi*ID_WIDTH +: ID_WIDTH];
                    end
                end
                assign head_id_flat[gi*ID_WIDTH +: ID_WIDTH] = id_mem[rd_ptr_reg];
            end else begin : g_no_id
                assign head_id_flat[gi*ID_WIDTH +: ID_WIDTH] = '0;
            end

            if (DEST_ENABLE != 0) begin : g_dest
                logic [DEST_WIDTH-1:0] dest_mem [FIFO_DEPTH];
                always_ff @(posedge clk) begin
                    if (push[gi]) begin
                        dest_mem[wr_ptr_reg] <= s_axis.tdest[gi*DEST_WIDTH +: DEST_WIDTH];
                    end
                end
                assign head_dest_flat[gi*DEST_WIDTH +: DEST_WIDTH] = dest_mem[rd_ptr_reg];
            end else begin : g_no_dest
                assign head_dest_flat[gi*DEST_WIDTH +: DEST_WIDTH] = '0;
            end

            if (USER_ENABLE != 0) begin : g_user
                logic [USER_WIDTH-1:0] user_mem [FIFO_DEPTH];
                always_ff @(posedge clk) begin
                    if (push[gi]) begin
                        user_mem[wr_ptr_reg] <= s_axis.tuser[gi*USER_WIDTH +: USER_WIDTH];
                    end
                end
                assign head_user_flat[gi*USER_WIDTH +: USER_WIDTH] = user_mem[rd_ptr_reg];
            end else begin : g_no_user
                assign head_user_flat[gi*USER_WIDTH +: USER_WIDTH] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Wide output: data from every head, sideband from lane 0
    // ------------------------------------------------------------------
    assign m_axis.tvalid = aligned;
    assign m_axis.tdata  = head_data_flat;
    assign m_axis.tlast  = head_last[0];
    assign m_axis.tid    = head_id_flat[ID_WIDTH-1:0];
    assign m_axis.tdest  = head_dest_flat[DEST_WIDTH-1:0];
    assign m_axis.tuser  = head_user_flat[USER_WIDTH-1:0];

    // Heads of the other lanes only feed the consistency checks, and disabled
    // input sideband is never stored.
    logic unused_sideband;
    assign unused_sideband = ^{s_axis.tid, s_axis.tdest, s_axis.tuser,
                               head_id_flat, head_user_flat};

    // ------------------------------------------------------------------
    // Lane consistency checks on the beat being popped
    // ------------------------------------------------------------------
    assign tlast_mismatch = ~((&head_last) | ~(|head_last));

    always_comb begin
        dest_mismatch = 1'b0;
        for (int i = 1; i < PE_NUMBER_I; i++) begin
            if (head_dest_flat[i*DEST_WIDTH +: DEST_WIDTH] != head_dest_flat[DEST_WIDTH-1:0]) begin
                dest_mismatch = 1'b1;
            end
        end
        if (DEST_ENABLE == 0) begin
            dest_mismatch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_en_reg   <= 1'b0;
            err_tlast_reg  <= 1'b0;
            err_dest_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            ready_en_reg   <= 1'b1;
            err_tlast_reg  <= pop & tlast_mismatch;
            err_dest_reg   <= pop & dest_mismatch;
            // Sticky rises in the same cycle as the pulse it records.
            err_sticky_reg <= err_sticky_reg | (pop & (tlast_mismatch | dest_mismatch));
        end
    end

    assign err_tlast_mismatch = err_tlast_reg;
    assign err_dest_mismatch  = err_dest_reg;
    assign err_sticky         = err_sticky_reg;

    // ------------------------------------------------------------------
    // Control FSM, driven by next-cycle occupancy
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_FILLING: begin
                if (&not_empty_next) begin
                    state_next = ST_ALIGNED;
                end else if (|not_empty_next) begin
                    state_next = ST_FILLING;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ALIGNED, ST_STALLED: begin
                if (&not_empty_next) begin
                    // Still aligned: stalled if the presented beat was refused.
                    state_next = (aligned & ~m_axis.tready) ? ST_STALLED : ST_ALIGNED;
                end else if (|not_empty_next) begin
                    state_next = ST_FILLING;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end
endmodule
